branch_predictor: RTL and testbench

- Fetch-side branch predictor. Supplies the taken prediction (`jump_taken`) and predicted target that the pipeline control carries to MEM.
- Consumes the control block's resolution outputs: `branch_resolved`, `actual_taken`, `mispredict`, plus resolved PC/target from the datapath.
- Direct-mapped BTB with a 2-bit saturating counter per entry. Lookup is combinational in IF; update is synchronous at MEM resolution.

---
 rtl/bp_pkg.sv | 31 +++
 rtl/sat_counter2.sv | 32 +++
 rtl/branch_predictor.sv | 143 ++++++++++++++
 tb/tb_branch_predictor.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : bp_pkg
//  Description : Shared definitions for the fetch-side branch predictor:
//                2-bit counter encodings, table geometry defaults and the
//                PC field positions used for index/tag extraction.
//  Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

    // 2-bit saturating counter states; MSB set means "predict taken"
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt_e;

    // Table geometry defaults (ENTRIES must equal 2**IDX_W)
    localparam int BP_ENTRIES = 64;
    localparam int BP_IDX_W   = 6;
    localparam int BP_TAG_W   = 24;

    // Instructions are word aligned, so PC[1:0] never takes part in lookup
    localparam int BP_IDX_LSB = 2;

    // Counter value a fresh, never-trained entry is considered to hold
    localparam logic [1:0] CNT_RESET = WNT;

endpackage : bp_pkg
`default_nettype wire

// File: rtl/sat_counter2.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter2
//  Description : Next-state function of a 2-bit saturating direction
//                counter. Taken moves towards ST, not-taken towards SNT,
//                both ends saturate.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter2
    import bp_pkg::*;
(
    input  logic [1:0] cnt,
    input  logic       taken,
    output logic [1:0] cnt_next
);

    // Saturating step in the direction of the resolved outcome
    always_comb begin
        cnt_next = cnt;
        if (taken) begin
            if (cnt != ST) begin
                cnt_next = cnt + 2'd1;
            end
        end else begin
            if (cnt != SNT) begin
                cnt_next = cnt - 2'd1;
            end
        end
    end

endmodule : sat_counter2
`default_nettype wire

// File: rtl/branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : branch_predictor
//  Description : Direct-mapped BTB with a 2-bit saturating counter per entry.
//                Combinational lookup on the fetch PC, synchronous training
//                from branch/jump resolution in MEM, plus two perf counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = BP_ENTRIES,
    parameter int IDX_W   = BP_IDX_W,
    parameter int TAG_W   = BP_TAG_W
) (
    input  logic        clk,
    input  logic        rst,

    input  logic [31:0] if_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,

    input  logic        upd_branch,
    input  logic        upd_jump,
    input  logic        upd_taken,
    input  logic        upd_mispredict,
    input  logic [31:0] upd_pc,
    input  logic [31:0] upd_target,

    output logic [31:0] perf_branches,
    output logic [31:0] perf_mispredicts
);

    localparam int TAG_LSB = IDX_W + BP_IDX_LSB;

    // Valid bits need a reset; the payload arrays do not and can map to LUT RAM
    logic [ENTRIES-1:0] r_valid;
    logic [TAG_W-1:0]   r_tag    [ENTRIES];
    logic [31:0]        r_target [ENTRIES];
    logic [1:0]         r_cnt    [ENTRIES];

    logic [31:0]        r_perf_branches;
    logic [31:0]        r_perf_mispredicts;

    logic [IDX_W-1:0]   w_if_idx;
    logic [TAG_W-1:0]   w_if_tag;
    logic               w_if_hit;

    logic [IDX_W-1:0]   w_upd_idx;
    logic [TAG_W-1:0]   w_upd_tag;
    logic               w_upd_hit;
    logic [1:0]         w_cnt_next;

    logic               w_write;
    logic               w_write_target;
    logic [1:0]         w_write_cnt;

    // PC alignment bits are deliberately ignored
    logic               w_unused_bits;
    assign w_unused_bits = ^{if_pc[1:0], upd_pc[1:0]};

    assign w_if_idx  = if_pc[TAG_LSB-1:BP_IDX_LSB];
    assign w_if_tag  = if_pc[TAG_LSB+TAG_W-1:TAG_LSB];
    assign w_upd_idx = upd_pc[TAG_LSB-1:BP_IDX_LSB];
    assign w_upd_tag = upd_pc[TAG_LSB+TAG_W-1:TAG_LSB];

    // Lookup: reads pre-update contents, so a same-cycle write shows next cycle
    always_comb begin
        w_if_hit    = r_valid[w_if_idx] && (r_tag[w_if_idx] == w_if_tag);
        pred_taken  = w_if_hit && r_cnt[w_if_idx][1];
        pred_target = pred_taken ? r_target[w_if_idx] : 32'd0;
    end

    assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

    sat_counter2 u_sat_counter2 (
        .cnt      (r_cnt[w_upd_idx]),
        .taken    (upd_taken),
        .cnt_next (w_cnt_next)
    );

    // Training decision; a jump overrides a simultaneous branch pulse
    always_comb begin
        w_write        = 1'b0;
        w_write_target = 1'b0;
        w_write_cnt    = w_cnt_next;
        if (upd_jump) begin
            w_write        = 1'b1;
            w_write_target = 1'b1;
            w_write_cnt    = ST;
        end else if (upd_branch) begin
            if (w_upd_hit) begin
                w_write        = 1'b1;
                w_write_target = upd_taken;
                w_write_cnt    = w_cnt_next;
            end else if (upd_taken) begin
                w_write        = 1'b1;
                w_write_target = 1'b1;
                w_write_cnt    = WT;
            end
        end
    end

    // Valid bits: cleared by reset, set on any allocation or refresh
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
        end else if (w_write) begin
            r_valid[w_upd_idx] <= 1'b1;
        end
    end

    // Payload arrays: no reset; writes during reset are suppressed
    always_ff @(posedge clk) begin
        if (!rst && w_write) begin
            r_tag[w_upd_idx] <= w_upd_tag;
            r_cnt[w_upd_idx] <= w_write_cnt;
            if (w_write_target) begin
                r_target[w_upd_idx] <= upd_target;
            end
        end
    end

    // Performance counters, free-running modulo 2^32
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_branches    <= 32'd0;
            r_perf_mispredicts <= 32'd0;
        end else begin
            if (upd_branch) begin
                r_perf_branches <= r_perf_branches + 32'd1;
            end
            if (upd_mispredict) begin
                r_perf_mispredicts <= r_perf_mispredicts + 32'd1;
            end
        end
    end

    assign perf_branches    = r_perf_branches;
    assign perf_mispredicts = r_perf_mispredicts;

endmodule : branch_predictor
`default_nettype wire

// File: tb/tb_branch_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_branch_predictor
//  Description : Self-checking bench for branch_predictor: directed vector
//                table, perf/reset sequence, then random traffic compared
//                against a behavioural table model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_predictor;

    localparam int ENTRIES = 64;

    logic        clk;
    logic        rst;
    logic [31:0] if_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_branch;
    logic        upd_jump;
    logic        upd_taken;
    logic        upd_mispredict;
    logic [31:0] upd_pc;
    logic [31:0] upd_target;
    logic [31:0] perf_branches;
    logic [31:0] perf_mispredicts;

    int checks = 0;
    int errors = 0;

    branch_predictor dut (
        .clk              (clk),
        .rst              (rst),
        .if_pc            (if_pc),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .upd_branch       (upd_branch),
        .upd_jump         (upd_jump),
        .upd_taken        (upd_taken),
        .upd_mispredict   (upd_mispredict),
        .upd_pc           (upd_pc),
        .upd_target       (upd_target),
        .perf_branches    (perf_branches),
        .perf_mispredicts (perf_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Branch and jump resolution must never be pulsed together
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(upd_branch && upd_jump))
                else $error("upd_branch and upd_jump asserted together");
        end
    end

    // ---------------- behavioural model ----------------
    bit          m_valid [ENTRIES];
    int unsigned m_tag   [ENTRIES];
    int unsigned m_tgt   [ENTRIES];
    int          m_cnt   [ENTRIES];
    int unsigned m_br;
    int unsigned m_mp;

    function automatic int unsigned slot(input logic [31:0] pc);
        return (pc / 4) % ENTRIES;
    endfunction

    function automatic int unsigned tagof(input logic [31:0] pc);
        return pc / (ENTRIES * 4);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
        m_br = 0;
        m_mp = 0;
    endfunction

    function automatic void model_lookup(input logic [31:0] pc,
                                         output bit tk, output logic [31:0] tg);
        int unsigned s;
        s  = slot(pc);
        tk = m_valid[s] && (m_tag[s] == tagof(pc)) && (m_cnt[s] >= 2);
        tg = tk ? m_tgt[s] : 32'd0;
    endfunction

    // Applies one clock edge worth of training with the inputs then present
    function automatic void model_clock();
        int unsigned s;
        bit hit;
        if (rst) begin
            model_reset();
            return;
        end
        s   = slot(upd_pc);
        hit = m_valid[s] && (m_tag[s] == tagof(upd_pc));
        if (upd_jump) begin
            m_valid[s] = 1'b1; m_tag[s] = tagof(upd_pc);
            m_tgt[s] = upd_target; m_cnt[s] = 3;
        end else if (upd_branch) begin
            if (hit && upd_taken) begin
                m_cnt[s] = (m_cnt[s] == 3) ? 3 : m_cnt[s] + 1;
                m_tgt[s] = upd_target;
            end else if (hit) begin
                m_cnt[s] = (m_cnt[s] == 0) ? 0 : m_cnt[s] - 1;
            end else if (upd_taken) begin
                m_valid[s] = 1'b1; m_tag[s] = tagof(upd_pc);
                m_tgt[s] = upd_target; m_cnt[s] = 2;
            end
        end
        if (upd_branch) m_br = m_br + 1;
        if (upd_mispredict) m_mp = m_mp + 1;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic check_model(input string tag);
        bit          tk;
        logic [31:0] tg;
        model_lookup(if_pc, tk, tg);
        check({tag, " pred_taken"},  {31'd0, pred_taken}, {31'd0, tk});
        check({tag, " pred_target"}, pred_target, tg);
        check({tag, " perf_branches"},    perf_branches,    m_br);
        check({tag, " perf_mispredicts"}, perf_mispredicts, m_mp);
    endtask

    task automatic idle_inputs();
        upd_branch = 0; upd_jump = 0; upd_taken = 0; upd_mispredict = 0;
        upd_pc = 0; upd_target = 0;
    endtask

    // Inputs are applied after the rising edge; DUT sampled at the falling edge
    task automatic finish_cycle();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        finish_cycle();
        finish_cycle();
        rst = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [31:0] pc;
        logic        br;
        logic        jmp;
        logic        tk;
        logic        mp;
        logic [31:0] upc;
        logic [31:0] utgt;
        logic        exp_tk;
        logic [31:0] exp_tgt;
    } vec_t;

    vec_t vecs[17];

    initial begin
        rst = 1'b1;
        if_pc = 32'h100;
        idle_inputs();

        //            pc       br jmp tk mp upc      utgt     exp_tk exp_tgt
        vecs[0]  = '{32'h100,  0, 0, 0, 0, 32'h0,    32'h0,   0, 32'h0};
        vecs[1]  = '{32'h100,  1, 0, 1, 1, 32'h100,  32'h80,  0, 32'h0};
        vecs[2]  = '{32'h100,  1, 0, 0, 1, 32'h100,  32'h80,  1, 32'h80};
        vecs[3]  = '{32'h100,  1, 0, 0, 0, 32'h100,  32'h80,  0, 32'h0};
        vecs[4]  = '{32'h100,  1, 0, 0, 0, 32'h100,  32'h80,  0, 32'h0};
        vecs[5]  = '{32'h100,  1, 0, 1, 1, 32'h100,  32'h80,  0, 32'h0};
        vecs[6]  = '{32'h100,  1, 0, 1, 1, 32'h100,  32'h80,  0, 32'h0};
        vecs[7]  = '{32'h100,  1, 0, 1, 0, 32'h100,  32'h80,  1, 32'h80};
        vecs[8]  = '{32'h100,  1, 0, 1, 0, 32'h100,  32'h80,  1, 32'h80};
        vecs[9]  = '{32'h100,  1, 0, 0, 0, 32'h100,  32'h80,  1, 32'h80};
        vecs[10] = '{32'h100,  0, 0, 0, 0, 32'h0,    32'h0,   1, 32'h80};
        vecs[11] = '{32'h100,  1, 0, 1, 0, 32'h1100, 32'h300, 1, 32'h80};
        vecs[12] = '{32'h100,  0, 0, 0, 0, 32'h0,    32'h0,   0, 32'h0};
        vecs[13] = '{32'h1100, 0, 0, 0, 0, 32'h0,    32'h0,   1, 32'h300};
        vecs[14] = '{32'h200,  0, 1, 1, 0, 32'h200,  32'h400, 0, 32'h0};
        vecs[15] = '{32'h200,  0, 0, 0, 0, 32'h0,    32'h0,   1, 32'h400};
        vecs[16] = '{32'h1100, 0, 0, 0, 0, 32'h0,    32'h0,   0, 32'h0};

        model_reset();
        do_reset();

        @(negedge clk);
        check("reset perf_branches", perf_branches, 32'd0);
        check("reset perf_mispredicts", perf_mispredicts, 32'd0);

        for (int i = 0; i < 17; i++) begin
            if_pc          = vecs[i].pc;
            upd_branch     = vecs[i].br;
            upd_jump       = vecs[i].jmp;
            upd_taken      = vecs[i].tk;
            upd_mispredict = vecs[i].mp;
            upd_pc         = vecs[i].upc;
            upd_target     = vecs[i].utgt;
            @(negedge clk);
            check($sformatf("vec%0d pred_taken", i), {31'd0, pred_taken}, {31'd0, vecs[i].exp_tk});
            check($sformatf("vec%0d pred_target", i), pred_target, vecs[i].exp_tgt);
            check_model($sformatf("vec%0d model", i));
            finish_cycle();
        end
        idle_inputs();

        // Perf counters: 5 branches, 2 of them mispredicted
        do_reset();
        for (int i = 0; i < 5; i++) begin
            upd_branch     = 1'b1;
            upd_taken      = i[0];
            upd_mispredict = (i == 1 || i == 3);
            upd_pc         = 32'h40 + 32'(i * 4);
            upd_target     = 32'h800;
            finish_cycle();
        end
        idle_inputs();
        if_pc = 32'h44;
        @(negedge clk);
        check("perf5 branches", perf_branches, 32'd5);
        check("perf5 mispredicts", perf_mispredicts, 32'd2);
        check("perf5 trained lookup", {31'd0, pred_taken}, 32'd1);
        finish_cycle();

        // Reset concurrent with a jump update: update dropped, counters cleared
        rst = 1'b1;
        upd_jump = 1'b1; upd_pc = 32'h500; upd_target = 32'h900;
        upd_mispredict = 1'b1;
        finish_cycle();
        rst = 1'b0;
        idle_inputs();
        if_pc = 32'h500;
        @(negedge clk);
        check("rst+upd perf_branches", perf_branches, 32'd0);
        check("rst+upd perf_mispredicts", perf_mispredicts, 32'd0);
        check("rst+upd dropped jump", {31'd0, pred_taken}, 32'd0);
        if_pc = 32'h44;
        #1;
        check("rst cleared entry", {31'd0, pred_taken}, 32'd0);
        check("rst cleared target", pred_target, 32'd0);
        finish_cycle();

        // Random traffic over a small address pool so entries get reused
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] a, b;
            int k;
            a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            b = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 7) << 2) | $urandom_range(0, 3);
            rst = ($urandom_range(0, 299) == 0);
            if_pc = a;
            k = $urandom_range(0, 9);
            upd_branch     = (k < 6);
            upd_jump       = (k == 6);
            upd_taken      = $urandom_range(0, 1);
            upd_mispredict = $urandom_range(0, 3) == 0;
            upd_pc         = b;
            upd_target     = $urandom;
            @(negedge clk);
            if (!rst) check_model($sformatf("rand%0d", n));
            finish_cycle();
        end
        rst = 1'b0;
        idle_inputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_branch_predictor
`default_nettype wire
